next_pc_ctrl: RTL and testbench

//   Parametrised program-counter unit for the fetch stage.
//   - Owns the PC register.
//   - Selects the next PC from: sequential PC+4, branch, J/JAL, or JR target.
//   - Keeps a circular return-address stack (RAS) that is pushed on JAL and popped on JR.
//   - Exposes the RAS top to the fetch predictor and reports redirects to pipeline flush logic.

---
 rtl/next_pc_if.sv | 31 +++
 rtl/next_pc_ctrl.sv | 98 +++++++++
 tb/tb_next_pc_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/next_pc_if.sv
// Fetch-stage PC unit bus: control requests from the pipeline plus PC/RAS status back to it.
interface next_pc_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IMM_W  = 26,
  parameter int unsigned OFF_W  = 16
);
  logic              stall;
  logic              branch_taken;
  logic [OFF_W-1:0]  branch_off;
  logic              jump;
  logic              link;
  logic [IMM_W-1:0]  jump_imm;
  logic              jr;
  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              redirect;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;

  modport master (
    output stall, branch_taken, branch_off, jump, link, jump_imm, jr, jr_target,
    input  pc, pc_plus4, redirect, ras_top, ras_empty, ras_full
  );

  modport slave (
    input  stall, branch_taken, branch_off, jump, link, jump_imm, jr, jr_target,
    output pc, pc_plus4, redirect, ras_top, ras_empty, ras_full
  );
endinterface

// File: rtl/next_pc_ctrl.sv
// Program-counter unit: owns the PC, picks the next fetch address and keeps a circular
// return-address stack pushed on JAL and popped on JR.
module next_pc_ctrl #(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          IMM_W     = 26,
  parameter int unsigned          OFF_W     = 16,
  parameter int unsigned          RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0
) (
  input logic     clk,
  input logic     rst_n,
  next_pc_if.slave bus
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic              redirect_q, redirect_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, top_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] br_off_ext;
  logic [ADDR_W-1:0] br_target, jump_target;
  logic              push, pop, ras_nonempty;

  assign pc_plus4     = pc_q + ADDR_W'(4);
  // Word offset sign-extended to the address width, then scaled to bytes.
  assign br_off_ext   = {{(ADDR_W-OFF_W){bus.branch_off[OFF_W-1]}}, bus.branch_off} << 2;
  assign br_target    = pc_plus4 + br_off_ext;
  assign jump_target  = {pc_plus4[ADDR_W-1:IMM_W+2], bus.jump_imm, 2'b00};
  assign ras_nonempty = (cnt_q != '0);
  assign top_idx      = ptr_q - PTR_W'(1);

  // Branch overrides everything, so a taken branch never touches the RAS.
  assign push = ~bus.stall & ~bus.branch_taken & ~bus.jr & bus.jump & bus.link;
  assign pop  = ~bus.stall & ~bus.branch_taken & bus.jr & ras_nonempty;

  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    if (!bus.stall) begin
      redirect_d = 1'b1;
      if (bus.branch_taken) begin
        pc_d = br_target;
      end else if (bus.jr) begin
        pc_d = bus.jr_target;
      end else if (bus.jump) begin
        pc_d = jump_target;
      end else begin
        pc_d       = pc_plus4;
        redirect_d = 1'b0;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      if (push) begin
        ras_q[ptr_q] <= pc_plus4;
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.redirect  = redirect_q;
  assign bus.ras_top   = ras_nonempty ? ras_q[top_idx] : '0;
  assign bus.ras_empty = ~ras_nonempty;
  assign bus.ras_full  = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Directed bench for next_pc_ctrl: sequential fetch, jumps, wrapping branches, RAS and stalls.
module tb_next_pc_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  next_pc_if #(.ADDR_W(32), .IMM_W(26), .OFF_W(16)) bus ();

  next_pc_ctrl #(
    .ADDR_W(32), .IMM_W(26), .OFF_W(16), .RAS_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_off   = '0;
    bus.jump         = 1'b0;
    bus.link         = 1'b0;
    bus.jump_imm     = '0;
    bus.jr           = 1'b0;
    bus.jr_target    = '0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle();
    #3;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_redirect", 32'(bus.redirect), 32'h0);
    chk("rst_empty", 32'(bus.ras_empty), 32'h1);
    chk("rst_full", 32'(bus.ras_full), 32'h0);
    chk("rst_top", bus.ras_top, 32'h0);
    chk("rst_plus4", bus.pc_plus4, 32'h4);
    #9 rst_n = 1'b1;

    // 1: sequential fetch
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq_pc", bus.pc, 32'(4 * i));
      chk("seq_redirect", 32'(bus.redirect), 32'h0);
      chk("seq_empty", 32'(bus.ras_empty), 32'h1);
    end

    // 2: J-type keeps the upper PC bits
    bus.jr = 1'b1; bus.jr_target = 32'h1000_0008;
    step();
    chk("jr_setup_pc", bus.pc, 32'h1000_0008);
    chk("jr_setup_redirect", 32'(bus.redirect), 32'h1);
    chk("jr_setup_empty", 32'(bus.ras_empty), 32'h1);
    idle(); bus.jump = 1'b1; bus.jump_imm = 26'h000_0100;
    step();
    chk("jump_pc", bus.pc, 32'h1000_0400);
    chk("jump_redirect", 32'(bus.redirect), 32'h1);
    idle();
    step();
    chk("jump_after_pc", bus.pc, 32'h1000_0404);
    chk("jump_after_redirect", 32'(bus.redirect), 32'h0);

    // 3: negative branch wraps below zero; branch beats jr/JAL and wraps back up
    bus.jr = 1'b1; bus.jr_target = 32'h0000_0010;
    step();
    chk("br_setup_pc", bus.pc, 32'h0000_0010);
    idle(); bus.branch_taken = 1'b1; bus.branch_off = 16'hFFF8;
    step();
    chk("br_neg_pc", bus.pc, 32'hFFFF_FFF4);
    chk("br_neg_redirect", 32'(bus.redirect), 32'h1);
    bus.branch_off = 16'h0004; bus.jr = 1'b1; bus.jr_target = 32'h0000_0ABC;
    bus.jump = 1'b1; bus.link = 1'b1; bus.jump_imm = 26'h3;
    step();
    chk("br_prio_pc", bus.pc, 32'h0000_0008);
    chk("br_prio_empty", 32'(bus.ras_empty), 32'h1);

    // 4: five JALs into a depth-4 RAS, then four pops
    idle(); bus.jump = 1'b1; bus.jump_imm = 26'h40;
    step();
    chk("j100_pc", bus.pc, 32'h0000_0100);
    chk("j100_empty", 32'(bus.ras_empty), 32'h1);
    bus.link = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.jump_imm = 26'((i + 1) * 32'h40);
      step();
      chk("jal_pc", bus.pc, 32'((i + 1) * 32'h100));
      chk("jal_top", bus.ras_top, 32'(i * 32'h100 + 4));
      chk("jal_full", 32'(bus.ras_full), (i >= 4) ? 32'h1 : 32'h0);
      chk("jal_empty", 32'(bus.ras_empty), 32'h0);
    end
    idle(); bus.jr = 1'b1; bus.link = 1'b1; bus.jr_target = 32'h0000_0800;
    for (int k = 0; k < 4; k++) begin
      chk("pop_top", bus.ras_top, 32'((5 - k) * 32'h100 + 4));
      step();
      chk("pop_pc", bus.pc, 32'h0000_0800);
      chk("pop_full", 32'(bus.ras_full), 32'h0);
    end
    chk("pop_done_empty", 32'(bus.ras_empty), 32'h1);
    chk("pop_done_top", bus.ras_top, 32'h0);

    // 5: stall ignores controls, then the branch wins on release
    idle(); bus.jump = 1'b1; bus.link = 1'b1; bus.jump_imm = 26'h300;
    step();
    chk("s_jal_pc", bus.pc, 32'h0000_0C00);
    chk("s_jal_top", bus.ras_top, 32'h0000_0804);
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_off = 16'h0010;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", bus.pc, 32'h0000_0C00);
      chk("stall_redirect", 32'(bus.redirect), 32'h0);
      chk("stall_top", bus.ras_top, 32'h0000_0804);
      chk("stall_empty", 32'(bus.ras_empty), 32'h0);
    end
    bus.stall = 1'b0;
    step();
    chk("unstall_pc", bus.pc, 32'h0000_0C44);
    chk("unstall_redirect", 32'(bus.redirect), 32'h1);
    chk("unstall_top", bus.ras_top, 32'h0000_0804);

    // 6: jr on an empty RAS, then asynchronous reset mid-cycle
    idle(); bus.jr = 1'b1; bus.jr_target = 32'h0000_0900;
    step();
    chk("jr_pop_empty", 32'(bus.ras_empty), 32'h1);
    bus.jr_target = 32'h0000_0ABC;
    step();
    chk("jr_empty_pc", bus.pc, 32'h0000_0ABC);
    chk("jr_empty_empty", 32'(bus.ras_empty), 32'h1);
    idle(); bus.jump = 1'b1; bus.link = 1'b1; bus.jump_imm = 26'h10;
    step();
    chk("pre_rst_pc", bus.pc, 32'h0000_0040);
    chk("pre_rst_top", bus.ras_top, 32'h0000_0AC0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", bus.pc, 32'h0);
    chk("arst_redirect", 32'(bus.redirect), 32'h0);
    chk("arst_empty", 32'(bus.ras_empty), 32'h1);
    chk("arst_top", bus.ras_top, 32'h0);
    #2 rst_n = 1'b1;
    chk("post_rst_pc", bus.pc, 32'h0);
    step();
    chk("post_rst_seq", bus.pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
